// File: rtl/bp_resolve_if.sv
// Fetch/execute-side signal bundle of the branch resolution queue.
// The slave modport is the queue itself; master is whoever drives fetch/execute.
interface bp_resolve_if #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 14
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            enq_valid;
  logic [PC_W-1:0] enq_pc;
  logic            enq_pred;
  logic            enq_ready;
  logic            res_valid;
  logic            res_taken;
  logic [PC_W-1:0] res_target;
  logic            flush;
  logic            is_b_ope;
  logic            is_branch;
  logic [PC_W-1:0] w_pc;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic [CW-1:0]   count;
  logic            res_err;

  modport slave (
    input  enq_valid, enq_pc, enq_pred, res_valid, res_taken, res_target, flush,
    output enq_ready, is_b_ope, is_branch, w_pc, mispredict, redirect_pc, count, res_err
  );

  modport master (
    output enq_valid, enq_pc, enq_pred, res_valid, res_taken, res_target, flush,
    input  enq_ready, is_b_ope, is_branch, w_pc, mispredict, redirect_pc, count, res_err
  );
endinterface

// File: rtl/bp_resolve.sv
// In-order queue of predicted branches; resolves them at execute, trains the
// 2-bit predictor and redirects fetch on a mispredict.
module bp_resolve #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 14
) (
  input  logic         clk,
  input  logic         rst,
  bp_resolve_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PC_W-1:0] pc_mem_r [DEPTH];
  logic [DEPTH-1:0] pred_mem_r;
  logic [AW-1:0]   head_r, tail_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   head_nxt_s, tail_nxt_s;
  logic [CW-1:0]   count_nxt_s;

  logic            is_b_ope_r, is_branch_r, mispredict_r, res_err_r;
  logic [PC_W-1:0] w_pc_r, redirect_pc_r;

  logic            empty_s, full_s, kill_s, res_acc_s, mis_s, enq_acc_s;
  logic [PC_W-1:0] head_pc_s, redir_s;
  logic            head_pred_s;

  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == FULL_CNT);
  assign head_pc_s   = pc_mem_r[head_r];
  assign head_pred_s = pred_mem_r[head_r];

  // A mispredict kills any same-cycle enqueue since fetch is on the wrong path.
  assign kill_s    = bus.res_valid & ~empty_s & (bus.res_taken != head_pred_s);
  assign res_acc_s = bus.res_valid & ~empty_s & ~bus.flush;
  assign mis_s     = res_acc_s & (bus.res_taken != head_pred_s);
  assign enq_acc_s = bus.enq_valid & ~full_s & ~bus.flush & ~kill_s;
  assign redir_s   = bus.res_taken ? bus.res_target : (head_pc_s + PC_W'(1));

  // Pointer and occupancy next-state; flush outranks mispredict outranks normal flow.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (bus.flush || mis_s) begin
      head_nxt_s  = tail_r;
      count_nxt_s = {CW{1'b0}};
    end else begin
      if (res_acc_s) begin
        head_nxt_s = head_r + AW'(1);
      end else begin
        head_nxt_s = head_r;
      end
      if (enq_acc_s) begin
        tail_nxt_s = tail_r + AW'(1);
      end else begin
        tail_nxt_s = tail_r;
      end
      count_nxt_s = count_r + CW'(enq_acc_s) - CW'(res_acc_s);
    end
  end

  // Queue pointers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (enq_acc_s) begin
      pc_mem_r[tail_r]   <= bus.enq_pc;
      pred_mem_r[tail_r] <= bus.enq_pred;
    end
  end

  // Registered training / redirect outputs and the sticky empty-resolve error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_b_ope_r    <= 1'b0;
      is_branch_r   <= 1'b0;
      w_pc_r        <= {PC_W{1'b0}};
      mispredict_r  <= 1'b0;
      redirect_pc_r <= {PC_W{1'b0}};
      res_err_r     <= 1'b0;
    end else begin
      is_b_ope_r   <= res_acc_s;
      is_branch_r  <= res_acc_s & bus.res_taken;
      w_pc_r       <= res_acc_s ? head_pc_s : {PC_W{1'b0}};
      mispredict_r <= mis_s;
      if (mis_s) begin
        redirect_pc_r <= redir_s;
      end
      if (bus.res_valid && empty_s && !bus.flush) begin
        res_err_r <= 1'b1;
      end
    end
  end

  assign bus.enq_ready   = ~full_s;
  assign bus.count       = count_r;
  assign bus.is_b_ope    = is_b_ope_r;
  assign bus.is_branch   = is_branch_r;
  assign bus.w_pc        = w_pc_r;
  assign bus.mispredict  = mispredict_r;
  assign bus.redirect_pc = redirect_pc_r;
  assign bus.res_err     = res_err_r;
endmodule

// File: tb/tb_bp_resolve.sv
// Self-checking bench for bp_resolve: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bp_resolve;
  localparam int DEPTH = 8;
  localparam int PC_W  = 14;
  localparam int VW    = 1 + 1 + PC_W + 1 + PC_W + 4 + 1 + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  bp_resolve_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();
  bp_resolve #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model state
  ent_t            q[$];
  logic            m_b_ope, m_branch, m_mis, m_err;
  logic [PC_W-1:0] m_wpc, m_redir;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.is_b_ope, bus.is_branch, bus.w_pc, bus.mispredict, bus.redirect_pc,
            bus.count, bus.res_err, bus.enq_ready};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [3:0] c;
    c = 4'(q.size());
    return {m_b_ope, m_branch, m_wpc, m_mis, m_redir, c, m_err, (q.size() < DEPTH)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_b_ope = 1'b0; m_branch = 1'b0; m_mis = 1'b0; m_err = 1'b0;
    m_wpc = '0; m_redir = '0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then pass the edge.
  task automatic step(input logic ev, input logic [PC_W-1:0] ep, input logic epd,
                      input logic rv, input logic rt, input logic [PC_W-1:0] rtg,
                      input logic fl);
    ent_t h;
    ent_t n;
    bit   was_full;
    bus.enq_valid = ev; bus.enq_pc = ep; bus.enq_pred = epd;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg; bus.flush = fl;
    was_full = (q.size() == DEPTH);
    n.pc = ep; n.pred = epd;
    m_b_ope = 1'b0; m_branch = 1'b0; m_mis = 1'b0; m_wpc = '0;
    if (fl) begin
      q.delete();
    end else if (rv && q.size() == 0) begin
      m_err = 1'b1;
      if (ev) q.push_back(n);
    end else if (rv) begin
      h = q.pop_front();
      m_b_ope = 1'b1; m_branch = rt; m_wpc = h.pc;
      if (rt != h.pred) begin
        m_mis = 1'b1;
        m_redir = rt ? rtg : PC_W'((int'(h.pc) + 1) % (1 << PC_W));
        q.delete();
      end else if (ev && !was_full) begin
        q.push_back(n);
      end
    end else if (ev && !was_full) begin
      q.push_back(n);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic enq(input logic [PC_W-1:0] pc, input logic pred);
    step(1'b1, pc, pred, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic res(input logic taken, input logic [PC_W-1:0] tgt);
    step(1'b0, '0, 1'b0, 1'b1, taken, tgt, 1'b0);
  endtask

  task automatic test_reset();
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_pred = 1'b0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0; bus.flush = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    enq(14'h010, 1'b1);
    checks++;
    if (bus.count !== 4'd1) begin
      fails++; $display("FAIL basic_count1 got=%0d exp=1", bus.count);
    end
    res(1'b1, 14'h100);
    checks++;
    if ({bus.is_b_ope, bus.is_branch, bus.w_pc, bus.mispredict, bus.count} !==
        {1'b1, 1'b1, 14'h010, 1'b0, 4'd0}) begin
      fails++; $display("FAIL basic_train got=%h exp=%h", dut_vec(), model_vec());
    end
    idle();
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL basic_quiet got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_mispredict();
    enq(14'h020, 1'b1); enq(14'h021, 1'b0); enq(14'h030, 1'b1);
    res(1'b0, 14'h200);
    checks++;
    if ({bus.is_b_ope, bus.is_branch, bus.w_pc, bus.mispredict, bus.redirect_pc, bus.count} !==
        {1'b1, 1'b0, 14'h020, 1'b1, 14'h021, 4'd0}) begin
      fails++; $display("FAIL mispredict got=%h exp=%h", dut_vec(), model_vec());
    end
    res(1'b1, 14'h300);
    checks++;
    if ({bus.is_b_ope, bus.mispredict, bus.res_err, bus.redirect_pc} !==
        {1'b0, 1'b0, 1'b1, 14'h021}) begin
      fails++; $display("FAIL empty_resolve got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_pc_wrap();
    enq(14'h3FFF, 1'b0);
    res(1'b0, 14'h0123);
    checks++;
    if ({bus.is_b_ope, bus.w_pc, bus.mispredict} !== {1'b1, 14'h3FFF, 1'b0}) begin
      fails++; $display("FAIL wrap_correct got=%h exp=%h", dut_vec(), model_vec());
    end
    enq(14'h3FFF, 1'b1);
    res(1'b0, 14'h0123);
    checks++;
    if ({bus.mispredict, bus.redirect_pc} !== {1'b1, 14'h0000}) begin
      fails++; $display("FAIL wrap_redirect got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_full();
    logic [PC_W-1:0] pcs [DEPTH];
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcs[i] = PC_W'($urandom_range(0, 16383));
        enq(pcs[i], 1'b1);
      end
      checks++;
      if ({bus.enq_ready, bus.count} !== {1'b0, 4'd8}) begin
        fails++; $display("FAIL full_flags got=%b/%0d exp=0/8", bus.enq_ready, bus.count);
      end
      enq(14'h1555, 1'b0);
      checks++;
      if (bus.count !== 4'd8) begin
        fails++; $display("FAIL full_ninth got=%0d exp=8", bus.count);
      end
      for (int i = 0; i < DEPTH; i++) begin
        res(1'b1, 14'h0040);
        checks++;
        if ({bus.is_b_ope, bus.w_pc, bus.mispredict} !== {1'b1, pcs[i], 1'b0}) begin
          fails++; $display("FAIL full_order%0d got=%h exp=%h", i, bus.w_pc, pcs[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    enq(14'h100, 1'b1); enq(14'h101, 1'b0); enq(14'h102, 1'b1);
    step(1'b1, 14'h103, 1'b1, 1'b1, 1'b1, 14'h0777, 1'b0);
    checks++;
    if ({bus.count, bus.w_pc, bus.is_b_ope} !== {4'd3, 14'h100, 1'b1}) begin
      fails++; $display("FAIL b2b_correct got=%h exp=%h", dut_vec(), model_vec());
    end
    step(1'b1, 14'h104, 1'b1, 1'b1, 1'b1, 14'h0888, 1'b0);
    checks++;
    if ({bus.count, bus.mispredict, bus.redirect_pc} !== {4'd0, 1'b1, 14'h0888}) begin
      fails++; $display("FAIL b2b_mispredict got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) enq(PC_W'(14'h200 + i), 1'b0);
    step(1'b1, 14'h2FF, 1'b0, 1'b1, 1'b1, 14'h0999, 1'b1);
    checks++;
    if ({bus.count, bus.is_b_ope, bus.mispredict} !== {4'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL flush got=%h exp=%h", dut_vec(), model_vec());
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL flush_model got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 6), PC_W'($urandom_range(0, 16383)), 1'($urandom),
           1'($urandom_range(0, 9) < 4), 1'($urandom), PC_W'($urandom_range(0, 16383)),
           1'($urandom_range(0, 99) < 3));
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    enq(14'h0AA, 1'b1); enq(14'h0AB, 1'b0);
    res(1'b1, 14'h0010);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
    end
    @(posedge clk); #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL reset_suppress got=%h exp=%h", dut_vec(), model_vec());
    end
    bus.res_valid = 1'b0;
    rst = 1'b0;
    idle();
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL post_reset got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mispredict();
    test_reset();
    test_pc_wrap();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
